// File: rtl/game_timer.sv
// game_timer: pausable one-shot / periodic timeout timer driven by a clock
// prescaler. times_up is the active-low expired level, expire_pulse is a
// one-cycle strobe for each expiry, count is the live tick count and running
// is high while the timer is counting.
module game_timer #(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic             times_up,
  output logic             expire_pulse,
  output logic [WIDTH-1:0] count,
  output logic             running
);

  // A single-cycle prescale still needs a 1-bit register, which simply stays 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_count;
  logic [PW-1:0]      r_presc;
  logic [WIDTH-1:0]   r_limit_q;
  logic               r_periodic_q;
  logic               r_times_up;
  logic               r_expire_pulse;
  logic               r_running;

  state_t             w_state_next;
  logic [WIDTH-1:0]   w_count_next;
  logic [PW-1:0]      w_presc_next;
  logic [WIDTH-1:0]   w_limit_next;
  logic               w_periodic_next;
  logic               w_pulse_next;
  logic               w_tick;
  logic               w_hit;

  // The limit compare wraps naturally, so limit_q = 0 expires on all-ones -> 0.
  assign w_tick = (r_presc == PRESC_MAX);
  assign w_hit  = ((r_count + WIDTH'(1)) == r_limit_q);

  // Next-state and next-datapath decode for the three-state controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_presc_next    = r_presc;
    w_limit_next    = r_limit_q;
    w_periodic_next = r_periodic_q;
    w_pulse_next    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = RUN;
          w_limit_next    = limit;
          w_periodic_next = periodic;
          w_count_next    = '0;
          w_presc_next    = '0;
        end
      end

      RUN: begin
        if (!start) begin
          // Abort wins over an expiry landing on the same cycle.
          w_state_next = IDLE;
          w_count_next = '0;
          w_presc_next = '0;
        end else if (pause) begin
          // Hold everything; a pending expiry is simply deferred.
        end else if (w_tick) begin
          w_presc_next = '0;
          if (w_hit) begin
            w_pulse_next = 1'b1;
            if (r_periodic_q) begin
              w_count_next = '0;
            end else begin
              w_state_next = EXPIRED;
              w_count_next = r_limit_q;
            end
          end else begin
            w_count_next = r_count + WIDTH'(1);
          end
        end else begin
          w_presc_next = r_presc + PW'(1);
        end
      end

      EXPIRED: begin
        if (!start) begin
          w_state_next = IDLE;
          w_count_next = '0;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
        w_presc_next = '0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_presc        <= '0;
      r_limit_q      <= '0;
      r_periodic_q   <= 1'b0;
      r_times_up     <= 1'b1;
      r_expire_pulse <= 1'b0;
      r_running      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_presc        <= w_presc_next;
      r_limit_q      <= w_limit_next;
      r_periodic_q   <= w_periodic_next;
      r_times_up     <= (w_state_next != EXPIRED);
      r_expire_pulse <= w_pulse_next;
      r_running      <= (w_state_next == RUN);
    end
  end

  assign times_up     = r_times_up;
  assign expire_pulse = r_expire_pulse;
  assign count        = r_count;
  assign running      = r_running;

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: four instances with different WIDTH/PRESCALE share one
// stimulus stream. A tick-arithmetic model predicts each instance's outputs and
// is compared every cycle; literal checks pin the model at key edges.
module tb_game_timer;

  localparam int N = 4;
  localparam int W_A [N] = '{8, 8, 8, 4};
  localparam int P_A [N] = '{1, 4, 2, 1};

  logic       clock;
  logic       reset;
  logic       start;
  logic       pause;
  logic       periodic;
  logic [7:0] limit;

  wire [N-1:0] tu;
  wire [N-1:0] ep;
  wire [N-1:0] rn;
  wire [7:0]   cnt0;
  wire [7:0]   cnt1;
  wire [7:0]   cnt2;
  wire [3:0]   cnt3;

  int n_pass  = 0;
  int n_total = 0;

  game_timer #(.WIDTH(8), .PRESCALE(1)) d0 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .periodic(periodic), .limit(limit), .times_up(tu[0]),
    .expire_pulse(ep[0]), .count(cnt0), .running(rn[0]));
  game_timer #(.WIDTH(8), .PRESCALE(4)) d1 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .periodic(periodic), .limit(limit), .times_up(tu[1]),
    .expire_pulse(ep[1]), .count(cnt1), .running(rn[1]));
  game_timer #(.WIDTH(8), .PRESCALE(2)) d2 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .periodic(periodic), .limit(limit), .times_up(tu[2]),
    .expire_pulse(ep[2]), .count(cnt2), .running(rn[2]));
  game_timer #(.WIDTH(4), .PRESCALE(1)) d3 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .periodic(periodic), .limit(limit[3:0]), .times_up(tu[3]),
    .expire_pulse(ep[3]), .count(cnt3), .running(rn[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic longint dut_count(input int i);
    case (i)
      0:       return longint'(cnt0);
      1:       return longint'(cnt1);
      2:       return longint'(cnt2);
      default: return longint'(cnt3);
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks unpaused RUN cycles since start; ticks = active / PRESCALE.
  int     m_st    [N] = '{default: 0};   // 0 idle, 1 counting, 2 expired
  longint m_act   [N] = '{default: 0};
  longint m_len   [N] = '{default: 0};   // ticks per period (2^W for limit 0)
  bit     m_per   [N] = '{default: 0};
  bit     m_pulse [N] = '{default: 0};

  task automatic model_step(input int i);
    longint t;
    longint mask;
    mask = (64'd1 << W_A[i]) - 1;
    m_pulse[i] = 1'b0;
    if (reset) begin
      m_st[i] = 0; m_act[i] = 0; m_len[i] = 0; m_per[i] = 1'b0;
      return;
    end
    case (m_st[i])
      0: if (start) begin
        m_st[i]  = 1;
        m_act[i] = 0;
        t = longint'(limit) & mask;
        m_len[i] = (t == 0) ? (64'd1 << W_A[i]) : t;
        m_per[i] = periodic;
      end
      1: if (!start) begin
        m_st[i] = 0; m_act[i] = 0;
      end else if (!pause) begin
        m_act[i]++;
        if (m_act[i] % P_A[i] == 0) begin
          t = m_act[i] / P_A[i];
          if (m_per[i]) begin
            if (t % m_len[i] == 0) m_pulse[i] = 1'b1;
          end else if (t == m_len[i]) begin
            m_pulse[i] = 1'b1;
            m_st[i]    = 2;
          end
        end
      end
      default: if (!start) begin
        m_st[i] = 0; m_act[i] = 0;
      end
    endcase
  endtask

  function automatic longint model_count(input int i);
    longint ticks;
    ticks = m_act[i] / P_A[i];
    case (m_st[i])
      0:       return 0;
      2:       return m_len[i] % (64'd1 << W_A[i]);
      default: return m_per[i] ? (ticks % m_len[i]) : ticks;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < N; i++) model_step(i);
  end

  // Compare every instance against the model once per cycle, away from the edge.
  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("d%0d.times_up", i), longint'(tu[i]), longint'(m_st[i] != 2));
      check($sformatf("d%0d.expire_pulse", i), longint'(ep[i]), longint'(m_pulse[i]));
      check($sformatf("d%0d.running", i), longint'(rn[i]), longint'(m_st[i] == 1));
      check($sformatf("d%0d.count", i), dut_count(i), model_count(i));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; periodic = 1'b0; limit = 8'd0;
    cycles(2);
    check("reset.times_up", longint'(tu[0]), 1);
    check("reset.expire_pulse", longint'(ep[0]), 0);
    check("reset.running", longint'(rn[0]), 0);
    check("reset.count", dut_count(0), 0);
    reset = 1'b0;
    cycles(1);

    // Asynchronous reset mid-run, then held with start high.
    limit = 8'd5; start = 1'b1;
    cycles(4);
    check("midrun.count_before", dut_count(0), 3);
    #2 reset = 1'b1;
    #1;
    check("midrun.count_async", dut_count(0), 0);
    check("midrun.times_up_async", longint'(tu[0]), 1);
    check("midrun.running_async", longint'(rn[0]), 0);
    cycles(3);
    check("midrun.held_idle", longint'(rn[0]), 0);
    reset = 1'b0;
    cycles(3);
    start = 1'b0;
    cycles(2);

    // One-shot, limit 3: d1 (PRESCALE 4) expires at E0+12.
    limit = 8'd3; periodic = 1'b0; start = 1'b1;
    cycles(12);
    check("oneshot.pulse_e11", longint'(ep[1]), 0);
    check("oneshot.count_e11", dut_count(1), 2);
    cycles(1);
    check("oneshot.pulse_e12", longint'(ep[1]), 1);
    check("oneshot.times_up_e12", longint'(tu[1]), 0);
    check("oneshot.count_e12", dut_count(1), 3);
    cycles(1);
    check("oneshot.pulse_e13", longint'(ep[1]), 0);
    cycles(3);
    check("oneshot.count_hold", dut_count(1), 3);
    start = 1'b0;
    cycles(1);
    check("oneshot.times_up_clear", longint'(tu[1]), 1);
    check("oneshot.count_clear", dut_count(1), 0);
    cycles(1);

    // Periodic, limit 4: d0 strobes at E0+4, 8, 12 with times_up staying high.
    limit = 8'd4; periodic = 1'b1; start = 1'b1;
    cycles(4);
    check("periodic.count_e3", dut_count(0), 3);
    cycles(1);
    check("periodic.pulse_e4", longint'(ep[0]), 1);
    check("periodic.count_e4", dut_count(0), 0);
    cycles(4);
    check("periodic.pulse_e8", longint'(ep[0]), 1);
    check("periodic.times_up_e8", longint'(tu[0]), 1);
    cycles(4);
    check("periodic.pulse_e12", longint'(ep[0]), 1);
    start = 1'b0; periodic = 1'b0;
    cycles(2);

    // Pause: one-shot limit 6, d2 (PRESCALE 2), five paused cycles -> E0+17.
    limit = 8'd6; start = 1'b1;
    cycles(4);
    check("pause.count_before", dut_count(2), 1);
    pause = 1'b1;
    cycles(5);
    check("pause.count_frozen", dut_count(2), 1);
    pause = 1'b0;
    cycles(1);
    check("pause.count_resumed", dut_count(2), 2);
    cycles(7);
    check("pause.pulse_e16", longint'(ep[2]), 0);
    check("pause.count_e16", dut_count(2), 5);
    cycles(1);
    check("pause.pulse_e17", longint'(ep[2]), 1);
    check("pause.times_up_e17", longint'(tu[2]), 0);
    start = 1'b0;
    cycles(2);

    // Expiry deferred by pause on the expiry cycle: d0, limit 2.
    limit = 8'd2; start = 1'b1;
    cycles(2);
    pause = 1'b1;
    cycles(2);
    check("defer.no_pulse", longint'(ep[0]), 0);
    pause = 1'b0;
    cycles(1);
    check("defer.pulse", longint'(ep[0]), 1);
    start = 1'b0;
    cycles(2);

    // Wrap: d3 (WIDTH 4), limit 0 -> expiry at E0+16.
    limit = 8'd0; start = 1'b1;
    cycles(16);
    check("wrap.count_e15", dut_count(3), 15);
    check("wrap.pulse_e15", longint'(ep[3]), 0);
    cycles(1);
    check("wrap.pulse_e16", longint'(ep[3]), 1);
    check("wrap.times_up_e16", longint'(tu[3]), 0);
    check("wrap.count_e16", dut_count(3), 0);
    start = 1'b0;
    cycles(2);

    // start dropped on the expiry edge of a limit-3 run on d0: no strobe.
    limit = 8'd3; start = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(1);
    check("abort.pulse", longint'(ep[0]), 0);
    check("abort.times_up", longint'(tu[0]), 1);
    check("abort.running", longint'(rn[0]), 0);
    check("abort.count", dut_count(0), 0);
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
